// File: rtl/cirno_fdx_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cirno_fdx_unit: PC/fetch, decode with branch resolution, 8-bit ALU.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cirno_fdx_unit (
  input  logic       clk,
  input  logic       init,
  input  logic [8:0] start_address,
  input  logic       fetch_en,
  input  logic       decode_en,
  input  logic       alu_en,
  output logic [8:0] imem_addr,
  input  logic [8:0] imem_data,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [8:0] inst,
  output logic [2:0] inst_type,
  output logic [3:0] funct,
  output logic [1:0] r1,
  output logic [1:0] r2,
  output logic [5:0] immediate,
  output logic [7:0] result,
  output logic       cmp_flag,
  output logic       carry_flag,
  output logic       done
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_ALU  = 3'd1;
  localparam logic [2:0] TYPE_CTLI = 3'd2;
  localparam logic [2:0] TYPE_MOVE = 3'd3;
  localparam logic [2:0] TYPE_JMPR = 3'd4;
  localparam logic [2:0] TYPE_ST   = 3'd5;
  localparam logic [2:0] TYPE_LD   = 3'd6;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_OR    = 4'd3;
  localparam logic [3:0] FN_XOR   = 4'd4;
  localparam logic [3:0] FN_CMP   = 4'd5;
  localparam logic [3:0] FN_SH    = 4'd6;
  localparam logic [3:0] FN_INCC  = 4'd7;
  localparam logic [3:0] FN_SHLI  = 4'd8;
  localparam logic [3:0] FN_SHRI  = 4'd9;
  localparam logic [3:0] FN_ANDI  = 4'd10;
  localparam logic [3:0] FN_MOVIL = 4'd11;
  localparam logic [3:0] FN_MOVIH = 4'd12;

  logic [8:0] pc;
  logic [2:0] dec_type;
  logic [3:0] dec_funct;
  logic [1:0] dec_r1;
  logic [1:0] dec_r2;
  logic       is_ctl_reg;
  logic       jump_reg;
  logic       jump_rel;
  logic       halt_now;
  logic [8:0] pc_rel;

  assign imem_addr = pc;

  always_comb begin
    dec_type  = TYPE_NONE;
    dec_funct = 4'd0;
    dec_r1    = 2'd0;
    dec_r2    = 2'd0;
    case (inst[8:6])
      3'b000, 3'b001: begin
        dec_type  = TYPE_ALU;
        dec_funct = {1'b0, inst[6], inst[5:4]};
        dec_r1    = inst[3:2];
        dec_r2    = inst[1:0];
      end
      3'b010: begin
        dec_r1 = inst[3:2];
        dec_r2 = inst[1:0];
        case (inst[5:4])
          2'b00:   dec_type = TYPE_MOVE;
          2'b01:   dec_type = TYPE_ST;
          2'b10:   dec_type = TYPE_LD;
          default: dec_type = inst[1] ? TYPE_CTLI : TYPE_JMPR;
        endcase
      end
      3'b011: begin
        dec_type  = TYPE_ALU;
        dec_funct = inst[3] ? FN_SHRI : FN_SHLI;
        dec_r1    = inst[5:4];
      end
      3'b100: begin
        dec_type  = TYPE_ALU;
        dec_funct = FN_ANDI;
        dec_r1    = inst[5:4];
      end
      3'b101: begin
        dec_type  = TYPE_MOVE;
        dec_funct = FN_MOVIL;
        dec_r1    = inst[5:4];
      end
      3'b110: begin
        dec_type  = TYPE_MOVE;
        dec_funct = FN_MOVIH;
        dec_r1    = inst[5:4];
      end
      default: dec_type = TYPE_CTLI;
    endcase
  end

  // Branch resolution uses the PC as it stands, which already points past the branch.
  assign is_ctl_reg = (inst[8:6] == 3'b010) && (inst[5:4] == 2'b11);
  assign jump_reg   = is_ctl_reg && ((inst[1:0] == 2'b00) || ((inst[1:0] == 2'b01) && cmp_flag));
  assign halt_now   = is_ctl_reg && (inst[1:0] == 2'b11);
  assign jump_rel   = (inst[8:6] == 3'b111) && (!inst[5] || cmp_flag);
  assign pc_rel     = pc + {{4{inst[4]}}, inst[4:0]};

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      pc   <= start_address;
      inst <= 9'd0;
      done <= 1'b0;
    end else if (!done) begin
      if (fetch_en) inst <= imem_data;
      if (decode_en && jump_reg)      pc <= {1'b0, x};
      else if (decode_en && jump_rel) pc <= pc_rel;
      else if (fetch_en)              pc <= pc + 9'd1;
      if (decode_en && halt_now) done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      inst_type <= TYPE_NONE;
      funct     <= 4'd0;
      r1        <= 2'd0;
      r2        <= 2'd0;
      immediate <= 6'd0;
    end else if (decode_en && !done) begin
      inst_type <= dec_type;
      funct     <= dec_funct;
      r1        <= dec_r1;
      r2        <= dec_r2;
      immediate <= inst[5:0];
    end
  end

  logic [7:0] alu_res;
  logic       alu_carry;
  logic       alu_cmp;
  logic       alu_wr;
  logic [8:0] sum9;
  logic [2:0] neg_amt;

  assign neg_amt = 3'd0 - y[2:0];

  always_comb begin
    alu_res   = result;
    alu_carry = carry_flag;
    alu_cmp   = cmp_flag;
    alu_wr    = 1'b0;
    sum9      = 9'd0;
    if (inst_type == TYPE_ALU) begin
      alu_wr = 1'b1;
      case (funct)
        FN_ADD: begin
          sum9      = {1'b0, x} + {1'b0, y};
          alu_res   = sum9[7:0];
          alu_carry = sum9[8];
        end
        FN_SUB: begin
          alu_res   = x - y;
          alu_carry = (x < y);
        end
        FN_INCC: begin
          sum9      = {1'b0, x} + {1'b0, y} + {8'd0, carry_flag};
          alu_res   = sum9[7:0];
          alu_carry = sum9[8];
        end
        FN_AND:  alu_res = x & y;
        FN_OR:   alu_res = x | y;
        FN_XOR:  alu_res = x ^ y;
        FN_CMP: begin
          alu_res = {7'd0, x == y};
          alu_cmp = (x == y);
        end
        FN_SH:   alu_res = y[7] ? (x >> neg_amt) : (x << y[2:0]);
        FN_SHLI: alu_res = x << immediate[2:0];
        FN_SHRI: alu_res = x >> immediate[2:0];
        FN_ANDI: alu_res = x & {4'd0, immediate[3:0]};
        default: alu_wr = 1'b0;
      endcase
    end else if (inst_type == TYPE_MOVE) begin
      alu_wr = 1'b1;
      case (funct)
        FN_MOVIL: alu_res = {x[7:4], immediate[3:0]};
        FN_MOVIH: alu_res = {immediate[3:0], x[3:0]};
        default:  alu_res = y;
      endcase
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      result     <= 8'd0;
      cmp_flag   <= 1'b0;
      carry_flag <= 1'b0;
    end else if (alu_en && alu_wr) begin
      result     <= alu_res;
      cmp_flag   <= alu_cmp;
      carry_flag <= alu_carry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cirno_fdx_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cirno_fdx_unit: scoreboard bench with a behavioural reference.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cirno_fdx_unit;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic [8:0] start_address = 9'd0;
  logic       fetch_en = 1'b0, decode_en = 1'b0, alu_en = 1'b0;
  logic [8:0] imem_addr, imem_data = 9'd0, inst;
  logic [7:0] x = 8'd0, y = 8'd0, result;
  logic [2:0] inst_type;
  logic [3:0] funct;
  logic [1:0] r1, r2;
  logic [5:0] immediate;
  logic       cmp_flag, carry_flag, done;

  cirno_fdx_unit dut (
    .clk(clk), .init(init), .start_address(start_address),
    .fetch_en(fetch_en), .decode_en(decode_en), .alu_en(alu_en),
    .imem_addr(imem_addr), .imem_data(imem_data), .x(x), .y(y),
    .inst(inst), .inst_type(inst_type), .funct(funct), .r1(r1), .r2(r2),
    .immediate(immediate), .result(result), .cmp_flag(cmp_flag),
    .carry_flag(carry_flag), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] pc, inst;
    logic [2:0] ty;
    logic [3:0] fn;
    logic [1:0] r1, r2;
    logic [5:0] imm;
    logic [7:0] res;
    logic       cmp, carry, done;
  } st_t;

  st_t m;
  st_t q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Instruction meaning taken straight from the opcode table.
  task automatic model_decode();
    int op, sub;
    op = int'(m.inst) / 64;
    sub = (int'(m.inst) / 16) % 4;
    m.ty = 0; m.fn = 0; m.r1 = 0; m.r2 = 0;
    m.imm = m.inst[5:0];
    if (op <= 1) begin
      m.ty = 1; m.fn = 4'((op % 2) * 4 + sub);
      m.r1 = m.inst[3:2]; m.r2 = m.inst[1:0];
    end else if (op == 2) begin
      m.r1 = m.inst[3:2]; m.r2 = m.inst[1:0];
      if (sub == 0) m.ty = 3;
      else if (sub == 1) m.ty = 5;
      else if (sub == 2) m.ty = 6;
      else m.ty = (m.inst[1:0] >= 2) ? 3'd2 : 3'd4;
    end else if (op == 3) begin
      m.ty = 1; m.fn = m.inst[3] ? 4'd9 : 4'd8; m.r1 = m.inst[5:4];
    end else if (op == 4) begin
      m.ty = 1; m.fn = 10; m.r1 = m.inst[5:4];
    end else if (op == 5 || op == 6) begin
      m.ty = 3; m.fn = (op == 5) ? 4'd11 : 4'd12; m.r1 = m.inst[5:4];
    end else m.ty = 2;
  endtask

  task automatic model_branch(input logic [7:0] xv);
    int op, off;
    op = int'(m.inst) / 64;
    if (op == 2 && m.inst[5:4] == 2'b11) begin
      if (m.inst[1:0] == 0 || (m.inst[1:0] == 1 && m.cmp)) m.pc = {1'b0, xv};
      if (m.inst[1:0] == 3) m.done = 1'b1;
    end else if (op == 7 && (!m.inst[5] || m.cmp)) begin
      off = int'(m.inst[4:0]);
      if (off >= 16) off -= 32;
      m.pc = 9'((int'(m.pc) + off + 512) % 512);
    end
  endtask

  task automatic model_alu(input logic [7:0] xv, input logic [7:0] yv);
    int a, b, s, n;
    a = int'(xv); b = int'(yv);
    if (m.ty == 1) begin
      case (m.fn)
        0: begin s = a + b; m.res = 8'(s % 256); m.carry = (s > 255); end
        1: begin m.res = 8'((a - b + 256) % 256); m.carry = (a < b); end
        2: m.res = xv & yv;
        3: m.res = xv | yv;
        4: m.res = xv ^ yv;
        5: begin m.res = (a == b) ? 8'd1 : 8'd0; m.cmp = (a == b); end
        6: begin
          if (b < 128) m.res = 8'((a * (1 << (b % 8))) % 256);
          else begin n = (256 - b) % 8; m.res = 8'(a / (1 << n)); end
        end
        7: begin s = a + b + int'(m.carry); m.res = 8'(s % 256); m.carry = (s > 255); end
        8: m.res = 8'((a * (1 << (m.imm % 8))) % 256);
        9: m.res = 8'(a / (1 << (m.imm % 8)));
        10: m.res = 8'(a & (m.imm % 16));
        default: ;
      endcase
    end else if (m.ty == 3) begin
      if (m.fn == 11) m.res = 8'((a / 16) * 16 + m.imm % 16);
      else if (m.fn == 12) m.res = 8'((m.imm % 16) * 16 + a % 16);
      else m.res = yv;
    end
  endtask

  // kind: 0 fetch, 1 decode, 2 alu
  task automatic strobe(input int kind, input logic [8:0] d, input logic [7:0] xv, input logic [7:0] yv);
    @(negedge clk);
    imem_data = d; x = xv; y = yv;
    fetch_en = (kind == 0); decode_en = (kind == 1); alu_en = (kind == 2);
    if (kind == 0 && !m.done) begin m.inst = d; m.pc = m.pc + 9'd1; end
    if (kind == 1 && !m.done) begin model_branch(xv); model_decode(); end
    if (kind == 2) model_alu(xv, yv);
    q.push_back(m);
    @(negedge clk);
    fetch_en = 0; decode_en = 0; alu_en = 0;
  endtask

  task automatic op(input logic [8:0] d, input logic [7:0] xv, input logic [7:0] yv);
    strobe(0, d, xv, yv);
    strobe(1, d, xv, yv);
    strobe(2, d, xv, yv);
  endtask

  task automatic do_reset(input logic [8:0] a);
    @(negedge clk);
    init = 1; start_address = a;
    @(negedge clk);
    m = '0; m.pc = a;
    chk("rst_pc", imem_addr, a);
    chk("rst_state", {inst, inst_type, funct, r1, r2, immediate, result, cmp_flag, carry_flag, done}, 0);
    init = 0;
  endtask

  always @(posedge clk) begin
    if (!init && (fetch_en || decode_en || alu_en)) begin
      st_t e;
      #1;
      if (q.size() == 0) chk("queue_underflow", 1, 0);
      else begin
        e = q.pop_front();
        chk("pc", imem_addr, e.pc);
        chk("inst", inst, e.inst);
        chk("inst_type", inst_type, e.ty);
        chk("funct", funct, e.fn);
        chk("r1r2", {r1, r2}, {e.r1, e.r2});
        chk("immediate", immediate, e.imm);
        chk("result", result, e.res);
        chk("flags", {cmp_flag, carry_flag}, {e.cmp, e.carry});
        chk("done", done, e.done);
      end
    end
  end

  initial begin
    m = '0;
    do_reset(9'h010);
    strobe(0, 9'b000_00_01_10, 8'h00, 8'h00);
    chk("tp_fetch_pc", imem_addr, 9'h011);
    strobe(1, 9'd0, 8'h00, 8'h00);
    chk("tp_decode", {inst_type, funct, r1, r2}, {3'd1, 4'd0, 2'd1, 2'd2});
    strobe(2, 9'd0, 8'hF0, 8'h20);
    chk("tp_add", {result, carry_flag}, {8'h10, 1'b1});
    op(9'b001_11_00_00, 8'h01, 8'h01);
    chk("tp_incc", {result, carry_flag}, {8'h03, 1'b0});
    op(9'b001_01_00_00, 8'h55, 8'h55);
    chk("tp_cmp", cmp_flag, 1);
    op(9'b010_11_00_00, 8'h20, 8'h00);
    op(9'b111_1_11101, 8'h00, 8'h00);
    chk("tp_beqi_taken", imem_addr, 9'h01E);
    op(9'b001_01_00_00, 8'h01, 8'h02);
    op(9'b010_11_00_00, 8'h20, 8'h00);
    op(9'b111_1_11101, 8'h00, 8'h00);
    chk("tp_beqi_not", imem_addr, 9'h021);
    op(9'b010_11_00_00, 8'hAB, 8'h00);
    chk("tp_jmp", imem_addr, 9'h0AB);
    op(9'b001_10_00_00, 8'h81, 8'hFE);
    chk("tp_sh", result, 8'h20);
    op(9'b110_00_1100, 8'h05, 8'h00);
    chk("tp_movih", result, 8'hC5);
    op(9'b000_01_00_00, 8'h03, 8'h05);
    chk("tp_sub", {result, carry_flag}, {8'hFE, 1'b1});
    op(9'b011_00_1_011, 8'h80, 8'h00);
    chk("tp_shri", result, 8'h10);
    op(9'b010_11_00_11, 8'h00, 8'h00);
    chk("tp_halt", done, 1);
    strobe(0, 9'h1FF, 8'h00, 8'h00);
    strobe(1, 9'h1FF, 8'h77, 8'h00);
    @(posedge clk);
    #2 init = 1; start_address = 9'h055;
    #1 chk("tp_async_init", {done, imem_addr}, {1'b0, 9'h055});
    @(negedge clk);
    init = 0; m = '0; m.pc = 9'h055;

    for (int i = 0; i < 400; i++) begin
      if (m.done) do_reset(9'($urandom_range(0, 511)));
      op(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cirno_fdx_unit.md
# cirno_fdx_unit

Fetch/decode/execute front end of the Cirno 9-bit-instruction, 8-bit-data processor: program counter and instruction fetch, instruction decoder with branch resolution, and 8-bit ALU with compare/carry flags. Sits between the external instruction ROM, register file and data memory; the top-level sequencer drives the `fetch_en`/`decode_en`/`alu_en` strobes.

## Interface
- No parameters; PC 9 bits, data 8 bits, instruction 9 bits.
- clk  in  1  system clock, all state on rising edge
- init  in  1  reset; asynchronous, active-high
- start_address  in  9  PC value loaded while init high
- fetch_en / decode_en / alu_en  in  1 each  single-cycle stage strobes
- imem_addr  out  9  = PC (combinational)
- imem_data  in  9  instruction word at imem_addr (combinational ROM)
- x, y  in  8  register-file values of r1, r2
- inst  out  9  latched instruction
- inst_type  out  3  0 none, 1 ALU, 2 jmpi/beqi/nil/halt, 3 mv/movil/movih, 4 jmp/beq, 5 st, 6 ld
- funct  out  4  op selector (below); r1, r2  out  2 each; immediate  out  6
- result  out  8  registered ALU/move result
- cmp_flag, carry_flag  out  1 each
- done  out  1  halted

## Operation
- Encoding, op=inst[8:6]:
  - 000/001 R-ALU: funct={0,op[6],inst[5:4]}: 0 add,1 sub,2 and,3 or,4 xor,5 cmp,6 sh,7 incc; r1=[3:2], r2=[1:0].
  - 010 misc, r1=[3:2], r2=[1:0]; [5:4]: 00 mv (type3), 01 st (5), 10 ld (6), 11 control by r2 field: 00 jmp r1 (4), 01 beq r1 (4), 10 nil (2), 11 halt (2).
  - 011 shift imm: r1=[5:4], [3]=0 shli/1 shri, amount [2:0]; funct 8/9.
  - 100 andi: r1=[5:4], imm4=[3:0] zero-extended; funct 10.
  - 101 movil, 110 movih: r1=[5:4], imm4=[3:0]; funct 11/12.
  - 111 jmpi ([5]=0) / beqi ([5]=1), signed 5-bit offset [4:0].
  - immediate = inst[5:0] always; unused fields 0.
- fetch_en: inst<=imem_data; PC<=PC+1 (mod 512). Ignored when done=1.
- decode_en: register inst_type/funct/r1/r2/immediate from inst; resolve control: jmp PC<={0,x}; beq same if cmp_flag; jmpi PC<=PC+sext(off5) (PC already = branch addr+1); beqi same if cmp_flag; halt sets done. Not taken: PC unchanged.
- alu_en (type 1/3): result<=
  - add x+y, carry<=carry-out; sub x−y, carry<=borrow (x<y); incc x+y+carry, carry<=carry-out.
  - and/or/xor bitwise; andi x&{4'b0,imm4}.
  - cmp: result={7'b0,x==y}, cmp_flag<=(x==y).
  - sh: y[7]=0 → x<<y[2:0]; y[7]=1 → x>>(−y)[2:0], logical.
  - shli/shri logical by amount.
  - mv y; movil {x[7:4],imm4}; movih {imm4,x[3:0]}.
  - Flags change only where stated. alu_en on other types: no change.
- All arithmetic 8-bit wrap-around.

## Timing
- init high (async): PC<=start_address, inst=0, inst_type=0, all decode fields 0, result=0, flags=0, done=0; held while init high.
- fetch: inst valid one cycle after fetch_en. decode fields and redirect visible one cycle after decode_en. result/flags one cycle after alu_en.
- Strobes are mutually exclusive by contract; if fetch_en and decode_en coincide, decode redirect wins for PC, inst still loads.
- done stays 1 until init; decode_en after halt has no effect.
- Offsets wrap mod 512; jmp to x zero-extends.
- init mid-operation aborts everything immediately.

## Test plan
- Reset start_address=0x010 → imem_addr=0x010, done=0; fetch_en with imem_data=9'b000_00_01_10 → inst latched, PC=0x011; decode → inst_type=1, funct=0, r1=1, r2=2.
- add x=0xF0,y=0x20 → result 0x10, carry 1; incc next with x=1,y=1 → result 3, carry 0.
- cmp x=y=0x55 → cmp_flag 1; beqi offset −3 at addr 0x020 → PC 0x01E; with cmp_flag 0 → PC 0x021.
- jmp r1 with x=0xAB → PC 0x0AB; sh x=0x81,y=0xFE → 0x20; movih imm 0xC, x=0x05 → 0xC5.
- halt decoded → done=1; further fetch_en leaves PC/inst unchanged; async init mid-cycle clears done.
- sub x=0x03,y=0x05 → 0xFE, carry 1; shri 3 on 0x80 → 0x10.
